// File: rtl/cell_edit_arbiter.sv
// rtl/cell_edit_arbiter.sv - mouse cell edits and single-port cell RAM arbitration
//
// Purpose: converts mouse pixel position and button levels into set/clear edits
// on the 1-bit-per-cell Game of Life RAM. It shares the single RAM port with the
// life engine, giving one owner per cycle. Edits win, except that a sim request
// that has lost MAX_STALL cycles outranks them.
//
// Ports:
//   clock, reset                     system clock, synchronous active-high reset
//   edit_enable                      1 = mouse edits accepted (engine paused)
//   x_pos, y_pos                     mouse pixel coordinates
//   left_click, right_click          button levels (left sets, right clears)
//   sim_req/sim_we/sim_addr/sim_wdata engine access, held until sim_gnt
//   sim_gnt                          engine owns the RAM this cycle
//   ram_addr/ram_we/ram_wdata        RAM port (registered, ram_addr holds when idle)
//   ram_rdata                        RAM read data, one cycle after the address
//   cursor_addr                      cell under the cursor, 0 when off-grid
//   edit_busy                        edit pending or in progress
//
// Optional feature macro: CELL_EDIT_TOGGLE_EN (left press toggles the cell by
// read-modify-write instead of setting it).

module cell_edit_arbiter #(
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int CELL_SHIFT = 2,
  parameter int ADDR_W     = 11,
  parameter int MAX_STALL  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              edit_enable,
  input  logic [8:0]        x_pos,
  input  logic [8:0]        y_pos,
  input  logic              left_click,
  input  logic              right_click,
  input  logic              sim_req,
  input  logic              sim_we,
  input  logic [ADDR_W-1:0] sim_addr,
  input  logic              sim_wdata,
  output logic              sim_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_wdata,
  input  logic              ram_rdata,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              edit_busy
);

  localparam int STALL_W = $clog2(MAX_STALL + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_SIM,
    OWN_EDIT,
    OWN_EDIT_RD,
    OWN_EDIT_WR
  } owner_e;

  owner_e owner_q, owner_d;

  logic              prev_left_q, prev_right_q;
  logic              drag_q, drag_d;
  logic              drag_val_q, drag_val_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_val_q, pend_val_d;
  logic              pend_tog_q, pend_tog_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_wdata_q, ram_wdata_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;

  logic [8:0]        cx, cy;
  logic              on_grid;
  logic [ADDR_W-1:0] cell_addr;
  logic              both, left_rise, right_rise;
  logic              req, req_val, req_tog;

  assign cx        = x_pos >> CELL_SHIFT;
  assign cy        = y_pos >> CELL_SHIFT;
  assign on_grid   = (32'(cx) < GRID_W) && (32'(cy) < GRID_H);
  assign cell_addr = ADDR_W'(32'(cy) * GRID_W + 32'(cx));
  assign both       = left_click & right_click;
  assign left_rise  = left_click & ~prev_left_q;
  assign right_rise = right_click & ~prev_right_q;

  // Edit request: a fresh press of exactly one button, or drag painting onto a
  // new cell while the button that started the drag is still held.
  always_comb begin
    req     = 1'b0;
    req_val = 1'b0;
    req_tog = 1'b0;
    if (edit_enable && on_grid && !both) begin
      if (left_click) begin
`ifdef CELL_EDIT_TOGGLE_EN
        if (left_rise) begin
          req     = 1'b1;
          req_val = 1'b1;
          req_tog = 1'b1;
        end
`else
        if (left_rise || (drag_q && drag_val_q && (cell_addr != last_addr_q))) begin
          req     = 1'b1;
          req_val = 1'b1;
        end
`endif
      end else if (right_click) begin
        if (right_rise || (drag_q && !drag_val_q && (cell_addr != last_addr_q))) begin
          req = 1'b1;
        end
      end
    end
  end

  always_comb begin
    drag_d      = drag_q;
    drag_val_d  = drag_val_q;
    last_addr_d = last_addr_q;
    if (!edit_enable || both || (!left_click && !right_click)) begin
      drag_d = 1'b0;
    end else if (req) begin
      drag_d      = 1'b1;
      drag_val_d  = req_val;
      last_addr_d = cell_addr;
    end
  end

  // Owner for the next cycle. The write half of a toggle is never preempted.
  always_comb begin
    owner_d = OWN_NONE;
    if (owner_q == OWN_EDIT_RD) begin
      owner_d = OWN_EDIT_WR;
    end else if (pend_q && (!sim_req || (stall_q != STALL_MAX))) begin
      owner_d = pend_tog_q ? OWN_EDIT_RD : OWN_EDIT;
    end else if (sim_req) begin
      owner_d = OWN_SIM;
    end
  end

  // Depth-1 pending slot: a new request overwrites whatever is waiting.
  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_val_d  = pend_val_q;
    pend_tog_d  = pend_tog_q;
    if ((owner_d == OWN_EDIT) || (owner_d == OWN_EDIT_RD)) begin
      pend_d = 1'b0;
    end
    if (req) begin
      pend_d      = 1'b1;
      pend_addr_d = cell_addr;
      pend_val_d  = req_val;
      pend_tog_d  = req_tog;
    end
  end

  // Stall count is cleared when the grant is issued so that a continuously
  // requesting engine is served every MAX_STALL+1 cycles.
  always_comb begin
    stall_d = stall_q;
    if (owner_d == OWN_SIM) begin
      stall_d = '0;
    end else if (sim_req && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    case (owner_d)
      OWN_SIM: begin
        ram_addr_d  = sim_addr;
        ram_we_d    = sim_we;
        ram_wdata_d = sim_wdata;
      end
      OWN_EDIT: begin
        ram_addr_d  = pend_addr_q;
        ram_we_d    = 1'b1;
        ram_wdata_d = pend_val_q;
      end
      OWN_EDIT_RD: begin
        ram_addr_d = pend_addr_q;
      end
      OWN_EDIT_WR: begin
        ram_we_d = 1'b1;
      end
      default: begin
      end
    endcase
    cursor_d = on_grid ? cell_addr : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q      <= OWN_NONE;
      prev_left_q  <= 1'b1;
      prev_right_q <= 1'b1;
      drag_q       <= 1'b0;
      drag_val_q   <= 1'b0;
      last_addr_q  <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_val_q   <= 1'b0;
      pend_tog_q   <= 1'b0;
      stall_q      <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= 1'b0;
      cursor_q     <= '0;
    end else begin
      owner_q      <= owner_d;
      prev_left_q  <= left_click;
      prev_right_q <= right_click;
      drag_q       <= drag_d;
      drag_val_q   <= drag_val_d;
      last_addr_q  <= last_addr_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_val_q   <= pend_val_d;
      pend_tog_q   <= pend_tog_d;
      stall_q      <= stall_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      cursor_q     <= cursor_d;
    end
  end

  // Toggle write data comes straight from the read data returned this cycle.
  assign ram_wdata   = (owner_q == OWN_EDIT_WR) ? ~ram_rdata : ram_wdata_q;
  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign sim_gnt     = (owner_q == OWN_SIM);
  assign cursor_addr = cursor_q;
  assign edit_busy   = pend_q || (owner_q == OWN_EDIT) ||
                       (owner_q == OWN_EDIT_RD) || (owner_q == OWN_EDIT_WR);

endmodule

// File: tb/tb_cell_edit_arbiter.sv
// tb/tb_cell_edit_arbiter.sv - directed vector bench for cell_edit_arbiter

module tb_cell_edit_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        edit_enable;
  logic [8:0]  x_pos, y_pos;
  logic        left_click, right_click;
  logic        sim_req, sim_we, sim_wdata;
  logic [10:0] sim_addr;
  logic        sim_gnt;
  logic [10:0] ram_addr;
  logic        ram_we, ram_wdata;
  logic        ram_rdata;
  logic [10:0] cursor_addr;
  logic        edit_busy;

  int errors = 0;
  int checks = 0;

  cell_edit_arbiter dut (
    .clock       (clk),
    .reset       (reset),
    .edit_enable (edit_enable),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .left_click  (left_click),
    .right_click (right_click),
    .sim_req     (sim_req),
    .sim_we      (sim_we),
    .sim_addr    (sim_addr),
    .sim_wdata   (sim_wdata),
    .sim_gnt     (sim_gnt),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .cursor_addr (cursor_addr),
    .edit_busy   (edit_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int en, l, r, x, y, sreq, swe, saddr, swd;
    int we, addr, wd, gnt, busy, cur;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int en, input int l, input int r, input int x, input int y,
                       input int sreq, input int swe, input int saddr, input int swd);
    edit_enable = en[0];
    left_click  = l[0];
    right_click = r[0];
    x_pos       = x[8:0];
    y_pos       = y[8:0];
    sim_req     = sreq[0];
    sim_we      = swe[0];
    sim_addr    = saddr[10:0];
    sim_wdata   = swd[0];
  endtask

  initial begin
    int gnts, last_g, max_gap, edit_wr;
    logic quiet;

    reset = 1'b1;
    ram_rdata = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("reset sim_gnt", int'(sim_gnt), 0);
    chk("reset ram_we", int'(ram_we), 0);
    chk("reset ram_addr", int'(ram_addr), 0);
    chk("reset ram_wdata", int'(ram_wdata), 0);
    chk("reset cursor", int'(cursor_addr), 0);
    chk("reset edit_busy", int'(edit_busy), 0);
    reset = 1'b0;

`ifndef CELL_EDIT_TOGGLE_EN
    //              en l  r  x    y   sq sw sa   sd   we addr wd gnt busy cur
    vecs.push_back('{1, 0, 0, 10,  6,  0, 0, 0,   0,   0, 0,   0, 0, 0, 42});
    vecs.push_back('{1, 1, 0, 10,  6,  0, 0, 0,   0,   0, 0,   0, 0, 1, 42});
    vecs.push_back('{1, 1, 0, 10,  6,  0, 0, 0,   0,   1, 42,  1, 0, 1, 42});
    vecs.push_back('{1, 1, 0, 10,  6,  0, 0, 0,   0,   0, 42,  1, 0, 0, 42});
    vecs.push_back('{1, 0, 0, 10,  6,  0, 0, 0,   0,   0, 42,  1, 0, 0, 42});
    vecs.push_back('{1, 0, 0, 0,   0,  0, 0, 0,   0,   0, 42,  1, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 0,   0,  0, 0, 0,   0,   0, 42,  1, 0, 1, 0});
    vecs.push_back('{1, 1, 0, 4,   0,  0, 0, 0,   0,   1, 0,   1, 0, 1, 1});
    vecs.push_back('{1, 1, 0, 8,   0,  0, 0, 0,   0,   1, 1,   1, 0, 1, 2});
    vecs.push_back('{1, 1, 0, 12,  0,  0, 0, 0,   0,   1, 2,   1, 0, 1, 3});
    vecs.push_back('{1, 1, 0, 16,  0,  0, 0, 0,   0,   1, 3,   1, 0, 1, 4});
    vecs.push_back('{1, 1, 0, 20,  0,  0, 0, 0,   0,   1, 4,   1, 0, 1, 5});
    vecs.push_back('{1, 1, 0, 20,  0,  0, 0, 0,   0,   1, 5,   1, 0, 1, 5});
    vecs.push_back('{1, 1, 0, 20,  0,  0, 0, 0,   0,   0, 5,   1, 0, 0, 5});
    vecs.push_back('{1, 0, 0, 20,  0,  0, 0, 0,   0,   0, 5,   1, 0, 0, 5});
    vecs.push_back('{1, 0, 1, 200, 0,  0, 0, 0,   0,   0, 5,   1, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 200, 0,  0, 0, 0,   0,   0, 5,   1, 0, 0, 0});
    vecs.push_back('{1, 1, 1, 40,  40, 0, 0, 0,   0,   0, 5,   1, 0, 0, 410});
    vecs.push_back('{1, 1, 1, 44,  40, 0, 0, 0,   0,   0, 5,   1, 0, 0, 411});
    vecs.push_back('{1, 0, 0, 44,  40, 0, 0, 0,   0,   0, 5,   1, 0, 0, 411});
    vecs.push_back('{1, 0, 1, 44,  40, 0, 0, 0,   0,   0, 5,   1, 0, 1, 411});
    vecs.push_back('{1, 0, 1, 44,  40, 0, 0, 0,   0,   1, 411, 0, 0, 1, 411});
    vecs.push_back('{1, 0, 0, 44,  40, 0, 0, 0,   0,   0, 411, 0, 0, 0, 411});
    vecs.push_back('{1, 0, 0, 44,  40, 1, 1, 100, 1,   1, 100, 1, 1, 0, 411});
    vecs.push_back('{1, 0, 0, 44,  40, 0, 0, 0,   0,   0, 100, 1, 0, 0, 411});
    vecs.push_back('{1, 0, 0, 44,  40, 1, 0, 7,   0,   0, 7,   0, 1, 0, 411});
    vecs.push_back('{1, 0, 0, 44,  40, 0, 0, 0,   0,   0, 7,   0, 0, 0, 411});
    vecs.push_back('{1, 1, 0, 10,  6,  0, 0, 0,   0,   0, 7,   0, 0, 1, 42});
    vecs.push_back('{1, 1, 0, 10,  6,  1, 1, 9,   0,   1, 42,  1, 0, 1, 42});
    vecs.push_back('{1, 1, 0, 10,  6,  1, 1, 9,   0,   1, 9,   0, 1, 0, 42});
    vecs.push_back('{1, 0, 0, 10,  6,  0, 0, 0,   0,   0, 9,   0, 0, 0, 42});
    vecs.push_back('{0, 1, 0, 10,  6,  0, 0, 0,   0,   0, 9,   0, 0, 0, 42});
    vecs.push_back('{1, 0, 0, 10,  6,  0, 0, 0,   0,   0, 9,   0, 0, 0, 42});
    vecs.push_back('{1, 1, 0, 10,  6,  0, 0, 0,   0,   0, 9,   0, 0, 1, 42});
    vecs.push_back('{0, 1, 0, 10,  6,  0, 0, 0,   0,   1, 42,  1, 0, 1, 42});
    vecs.push_back('{0, 0, 0, 10,  6,  0, 0, 0,   0,   0, 42,  1, 0, 0, 42});

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].l, vecs[i].r, vecs[i].x, vecs[i].y,
            vecs[i].sreq, vecs[i].swe, vecs[i].saddr, vecs[i].swd);
      tick();
      chk($sformatf("row%0d ram_we", i), int'(ram_we), vecs[i].we);
      chk($sformatf("row%0d ram_addr", i), int'(ram_addr), vecs[i].addr);
      chk($sformatf("row%0d ram_wdata", i), int'(ram_wdata), vecs[i].wd);
      chk($sformatf("row%0d sim_gnt", i), int'(sim_gnt), vecs[i].gnt);
      chk($sformatf("row%0d edit_busy", i), int'(edit_busy), vecs[i].busy);
      chk($sformatf("row%0d cursor", i), int'(cursor_addr), vecs[i].cur);
    end

    // Button held through reset, pending edit lost, no edit until re-pressed.
    drive(1, 0, 0, 10, 6, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 10, 6, 0, 0, 0, 0);
    tick();
    chk("held pend busy", int'(edit_busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset drops pend busy", int'(edit_busy), 0);
    chk("reset drops pend we", int'(ram_we), 0);
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 14 + 4 * i, 6, 0, 0, 0, 0);
      tick();
      if (ram_we || edit_busy) quiet = 1'b0;
    end
    chk("held through reset quiet", int'(quiet), 1);
    drive(1, 0, 0, 30, 6, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 30, 6, 0, 0, 0, 0);
    tick();
    tick();
    chk("repress we", int'(ram_we), 1);
    chk("repress addr", int'(ram_addr), 47);
    chk("repress wdata", int'(ram_wdata), 1);

    // Continuous sim_req against drag edits every cycle.
    drive(1, 0, 0, 0, 8, 0, 0, 0, 0);
    tick();
    tick();
    gnts = 0;
    last_g = -1;
    max_gap = 0;
    edit_wr = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1, 1, 0, 4 * i, 8, 1, 0, 3, 0);
      tick();
      if (sim_gnt) begin
        if (last_g >= 0 && (i - last_g) > max_gap) max_gap = i - last_g;
        last_g = i;
        gnts++;
      end else if (ram_we) begin
        edit_wr++;
      end
    end
    chk("starve gnt count", gnts, 5);
    chk("starve max gap", max_gap, 9);
    chk("starve edit writes", edit_wr, 35);
    drive(1, 0, 0, 0, 8, 0, 0, 0, 0);
    tick();
    tick();
`else
    // Toggle: read 42, write ~rdata with no grant between, then toggle back.
    drive(1, 0, 0, 10, 6, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 10, 6, 1, 0, 3, 0);
    tick();
    chk("tog first sim gnt", int'(sim_gnt), 1);
    tick();
    chk("tog rd we", int'(ram_we), 0);
    chk("tog rd addr", int'(ram_addr), 42);
    chk("tog rd gnt", int'(sim_gnt), 0);
    chk("tog rd busy", int'(edit_busy), 1);
    ram_rdata = 1'b1;
    tick();
    chk("tog wr we", int'(ram_we), 1);
    chk("tog wr addr", int'(ram_addr), 42);
    chk("tog wr wdata", int'(ram_wdata), 0);
    chk("tog wr gnt", int'(sim_gnt), 0);
    chk("tog wr busy", int'(edit_busy), 1);
    drive(1, 1, 0, 10, 6, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 10, 6, 0, 0, 0, 0);
    tick();
    chk("tog idle busy", int'(edit_busy), 0);
    drive(1, 1, 0, 10, 6, 0, 0, 0, 0);
    tick();
    tick();
    chk("tog2 rd we", int'(ram_we), 0);
    ram_rdata = 1'b0;
    tick();
    chk("tog2 wr we", int'(ram_we), 1);
    chk("tog2 wr wdata", int'(ram_wdata), 1);
    drive(1, 1, 0, 14, 6, 0, 0, 0, 0);
    tick();
    tick();
    chk("tog no left drag", int'(ram_we), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
